multicycle_controller: RTL
==========================

# multicycle_controller

Multi-cycle control unit for the 16-bit accumulator CPU. It sequences fetch, decode, memory access, execute and write-back, and drives the datapath muxes, register enables and the `alu_op` code consumed by the 16-bit ALU. It also samples the ALU's `zero` output into an internal Z flag. It sits between the instruction register / memory interface and the datapath.

## Interface
- Parameters: none; the encodings below are fixed.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  4  IR[15:12]; valid from DECODE onward.
- `alu_zero`  in  1  `zero` output of the ALU.
- `mem_ready`  in  1  memory completes the current read or write this cycle.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `i_or_d`  out  1  address source: 0 = PC, 1 = IR[11:0].
- `ir_write`  out  1  load IR from memory data.
- `mdr_write`  out  1  load MDR from memory data.
- `pc_write`  out  1  load PC.
- `pc_src`  out  1  PC source: 0 = ALU result, 1 = IR[11:0].
- `acc_write`  out  1  load ACC.
- `acc_src`  out  1  ACC source: 0 = ALU result, 1 = MDR.
- `alu_src_a`  out  1  ALU A source: 0 = PC, 1 = ACC.
- `alu_src_b`  out  1  ALU B source: 0 = MDR, 1 = constant 1.
- `alu_op`  out  2  ALU operation: 00 = add, 01 = sub, 10 = and, 11 = not A.
- `halted`  out  1  high while the controller is in HALT.

## Operation
- Opcodes:
  - 0000 LDA
  - 0001 STA
  - 0010 ADD
  - 0011 SUB
  - 0100 AND
  - 0101 NOT
  - 0110 JMP
  - 0111 JZ
  - 1111 HLT
  - Any other opcode is a NOP.
- States: FETCH, DECODE, MEM_RD, LOAD_WB, EXEC, STORE, JUMP, HALT.
- Outputs are decoded from the state register, plus `mem_ready` where noted. Any output not listed for a state is 0.
- FETCH:
  - Drives `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=00.
  - If `mem_ready`: `ir_write`=1, `pc_write`=1 (`pc_src`=0, so PC ← PC+1), next state DECODE.
  - Otherwise stays in FETCH.
- DECODE: no outputs. Next state by opcode:
  - LDA, ADD, SUB, AND → MEM_RD.
  - STA → STORE.
  - NOT → EXEC.
  - JMP → JUMP.
  - JZ → JUMP if Z=1, else FETCH.
  - HLT → HALT.
  - NOP → FETCH.
- MEM_RD:
  - Drives `mem_read`=1, `i_or_d`=1.
  - If `mem_ready`: `mdr_write`=1, then next state is LOAD_WB for LDA, otherwise EXEC.
  - Otherwise stays in MEM_RD.
- LOAD_WB: `acc_write`=1, `acc_src`=1 → FETCH. Z is unchanged.
- EXEC:
  - Drives `alu_src_a`=1, `alu_src_b`=0, `acc_write`=1, `acc_src`=0.
  - `alu_op`: ADD 00, SUB 01, AND 10, NOT 11.
  - Z ← `alu_zero` at the clock edge → FETCH.
- STORE: `mem_write`=1, `i_or_d`=1. If `mem_ready` → FETCH, otherwise stays.
- JUMP: `pc_write`=1, `pc_src`=1 → FETCH.
- HALT: `halted`=1, all other outputs 0. Stays in HALT until `rst`.
- Z flag: 1 bit, updated only in EXEC, so only by ADD/SUB/AND/NOT.

## Timing
- Reset:
  - `rst` sampled high → state FETCH, Z=0 at that edge.
  - While `rst`=1, every output is forced to 0.
  - Reset mid-instruction abandons the instruction; no write enable may be asserted in the `rst` cycle.
- Cycle counts with `mem_ready` always 1:
  - LDA, ADD, SUB, AND: 4 cycles.
  - STA, NOT, JMP, taken JZ: 3 cycles.
  - Not-taken JZ, NOP: 2 cycles.
- Each cycle of `mem_ready`=0 in FETCH, MEM_RD or STORE adds one cycle.
- `ir_write`, `pc_write` (in FETCH) and `mdr_write` are combinational in `mem_ready`: high for exactly one cycle, the cycle in which `mem_ready`=1.
- `mem_read` and `mem_write` are never high together.
- JZ uses the Z value registered before DECODE. An instruction immediately before JZ has already finished, so its EXEC result is visible.

## Test plan
- ADD with `mem_ready`=1; ALU returns `alu_zero`=0 → state sequence FETCH, DECODE, MEM_RD, EXEC. `alu_op`=00 and `acc_write`=1 in cycle 4. Back in FETCH on cycle 5.
- LDA with `mem_ready` low for 3 cycles in MEM_RD → `mdr_write` pulses once, in the 4th MEM_RD cycle. LOAD_WB follows with `acc_src`=1. Total 7 cycles.
- SUB giving `alu_zero`=1, then JZ → JUMP entered and `pc_write`=1 with `pc_src`=1. Repeat with NOT giving `alu_zero`=0 → JZ returns to FETCH after 2 cycles.
- STA with `mem_ready`=0 for 2 cycles → `mem_write` high for 3 cycles with `i_or_d`=1, never with `mem_read`. Then FETCH.
- HLT → `halted`=1 and no enables for 20 cycles. `rst` pulse → FETCH with `mem_read`=1 the cycle after `rst` drops.
- `rst` asserted in EXEC of an AND → `acc_write`=0 in that cycle, Z stays 0, next state FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle control FSM for the 16-bit accumulator CPU
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       acc_write,
  output logic       acc_src,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic       halted
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_MEM_RD  = 3'd2;
  localparam logic [2:0] S_LOAD_WB = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_STORE   = 3'd5;
  localparam logic [2:0] S_JUMP    = 3'd6;
  localparam logic [2:0] S_HALT    = 3'd7;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_STA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JZ  = 4'b0111;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  logic [2:0] state_q, state_d;
  logic       z_q, z_d;

  // Next-state selection; memory states hold until mem_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_AND: state_d = S_MEM_RD;
          OP_STA:                         state_d = S_STORE;
          OP_NOT:                         state_d = S_EXEC;
          OP_JMP:                         state_d = S_JUMP;
          OP_JZ:                          state_d = z_q ? S_JUMP : S_FETCH;
          OP_HLT:                         state_d = S_HALT;
          default:                        state_d = S_FETCH;
        endcase
      end
      S_MEM_RD: begin
        if (mem_ready) state_d = (opcode == OP_LDA) ? S_LOAD_WB : S_EXEC;
      end
      S_LOAD_WB: state_d = S_FETCH;
      S_EXEC:    state_d = S_FETCH;
      S_STORE: begin
        if (mem_ready) state_d = S_FETCH;
      end
      S_JUMP:    state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
  end

  // Z flag captures the ALU zero output only when an ALU result is written back.
  always_comb begin
    z_d = z_q;
    if (state_q == S_EXEC) z_d = alu_zero;
  end

  // State and Z registers with synchronous reset; reset abandons any instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
    end
  end

  // Output decode from state (and mem_ready for the one-cycle load strobes); all zero in reset.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    i_or_d    = 1'b0;
    ir_write  = 1'b0;
    mdr_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    acc_write = 1'b0;
    acc_src   = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    halted    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 1'b1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_MEM_RD: begin
          mem_read  = 1'b1;
          i_or_d    = 1'b1;
          mdr_write = mem_ready;
        end
        S_LOAD_WB: begin
          acc_write = 1'b1;
          acc_src   = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          acc_write = 1'b1;
          case (opcode)
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            OP_NOT:  alu_op = ALU_NOT;
            default: alu_op = ALU_ADD;
          endcase
        end
        S_STORE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: begin
          halted = 1'b0;
        end
      endcase
    end
  end

endmodule
